writeback_regfile: RTL and testbench

WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

---
 rtl/pipes_pkg.sv | 27 ++
 rtl/regfile.sv | 30 +++
 rtl/writeback_regfile.sv | 95 +++++++++
 tb/tb_writeback_regfile.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipes_pkg.sv
// Shared pipeline types: register-file words, register addresses, the
// forwarding bundle and the writeback-stage register.
package pipes_pkg;

    localparam int XLEN  = 64;
    localparam int NREGS = 32;

    typedef logic [XLEN-1:0] word_t;
    typedef logic [4:0]      creg_addr_t;

    typedef struct packed {
        logic       valid;
        creg_addr_t dst;
        word_t      data;
    } tran_t;

    // done is set once the entry has written its GPR and pulsed commit.
    typedef struct packed {
        logic       valid;
        word_t      pc;
        logic       wen;
        creg_addr_t dst;
        word_t      data;
        logic       done;
    } wb_data_t;

endpackage

// File: rtl/regfile.sv
// 32x64 general-purpose register file: two asynchronous read ports,
// one synchronous write port, x0 hardwired to zero.
module regfile
    import pipes_pkg::*;
(
    input  logic       clk,
    input  logic       we,
    input  creg_addr_t wa,
    input  word_t      wd,
    input  creg_addr_t ra1,
    input  creg_addr_t ra2,
    output word_t      rd1,
    output word_t      rd2
);

    word_t mem [NREGS];

    always_ff @(posedge clk) begin
        if (we && wa != '0) begin
            mem[wa] <= wd;
        end
    end

    // x0 is decoded on the read side so the storage never needs a reset.
    always_comb begin
        rd1 = (ra1 == '0) ? '0 : mem[ra1];
        rd2 = (ra2 == '0) ? '0 : mem[ra2];
    end

endmodule

// File: rtl/writeback_regfile.sv
// Writeback stage with the GPR file; each WB entry writes and commits once.
// Define WB_READ_BYPASS_EN to let decode reads see the not-yet-written WB result.
module writeback_regfile
    import pipes_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        m_valid,
    input  logic [63:0] m_pc,
    input  logic        m_wen,
    input  logic [4:0]  m_dst,
    input  logic [63:0] m_data,
    input  logic        hold,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [63:0] rd1,
    output logic [63:0] rd2,
    output tran_t       tranw,
    output logic        commit_valid,
    output logic [63:0] commit_pc,
    output logic [63:0] commit_wdata,
    output logic [63:0] instret
);

    wb_data_t wb;
    logic     wb_live;
    logic     rf_we;
    word_t    rf_rd1;
    word_t    rf_rd2;

    // A held entry is marked done after its first cycle so it never writes or commits again.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb.valid <= 1'b0;
            wb.done  <= 1'b0;
        end else if (!hold) begin
            wb.valid <= m_valid;
            wb.pc    <= m_pc;
            wb.wen   <= m_wen;
            wb.dst   <= m_dst;
            wb.data  <= m_data;
            wb.done  <= 1'b0;
        end else begin
            wb.done  <= wb.done | wb.valid;
        end
    end

    always_comb begin
        wb_live      = wb.valid & ~wb.done & ~reset;
        rf_we        = wb_live & wb.wen & (wb.dst != '0);
        tranw.valid  = wb.valid & wb.wen & (wb.dst != '0) & ~reset;
        tranw.dst    = wb.dst;
        tranw.data   = wb.data;
        commit_valid = wb_live;
        commit_pc    = wb.pc;
        commit_wdata = wb.wen ? wb.data : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instret <= '0;
        end else if (commit_valid) begin
            instret <= instret + 64'd1;
        end
    end

    regfile u_regfile (
        .clk (clk),
        .we  (rf_we),
        .wa  (wb.dst),
        .wd  (wb.data),
        .ra1 (ra1),
        .ra2 (ra2),
        .rd1 (rf_rd1),
        .rd2 (rf_rd2)
    );

`ifdef WB_READ_BYPASS_EN
    // Write-through: the array only catches up at the next edge.
    always_comb begin
        rd1 = rf_rd1;
        rd2 = rf_rd2;
        if (tranw.valid && !wb.done && ra1 == wb.dst) begin
            rd1 = wb.data;
        end
        if (tranw.valid && !wb.done && ra2 == wb.dst) begin
            rd2 = wb.data;
        end
    end
`else
    assign rd1 = rf_rd1;
    assign rd2 = rf_rd2;
`endif

endmodule

// File: tb/tb_writeback_regfile.sv
// Self-checking bench for writeback_regfile: expected commits are queued when an
// entry is driven and popped when commit_valid is seen.
module tb_writeback_regfile;
    import pipes_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        m_valid;
    logic [63:0] m_pc;
    logic        m_wen;
    logic [4:0]  m_dst;
    logic [63:0] m_data;
    logic        hold;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [63:0] rd1;
    logic [63:0] rd2;
    tran_t       tranw;
    logic        commit_valid;
    logic [63:0] commit_pc;
    logic [63:0] commit_wdata;
    logic [63:0] instret;

    typedef struct {
        logic [63:0] pc;
        logic [63:0] wdata;
    } commit_t;

    commit_t     sb[$];
    commit_t     c;
    int          checks = 0;
    int          passed = 0;
    logic [63:0] exp_instret = '0;

    writeback_regfile dut (
        .clk          (clk),
        .reset        (reset),
        .m_valid      (m_valid),
        .m_pc         (m_pc),
        .m_wen        (m_wen),
        .m_dst        (m_dst),
        .m_data       (m_data),
        .hold         (hold),
        .ra1          (ra1),
        .ra2          (ra2),
        .rd1          (rd1),
        .rd2          (rd2),
        .tranw        (tranw),
        .commit_valid (commit_valid),
        .commit_pc    (commit_pc),
        .commit_wdata (commit_wdata),
        .instret      (instret)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_entry(input logic [63:0] pc, input logic wen, input logic [4:0] dst,
                               input logic [63:0] data, input bit will_commit);
        m_valid = 1'b1;
        m_pc    = pc;
        m_wen   = wen;
        m_dst   = dst;
        m_data  = data;
        if (will_commit) begin
            sb.push_back('{pc: pc, wdata: (wen ? data : 64'd0)});
            exp_instret = exp_instret + 64'd1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; m_valid = 1'b0; hold = 1'b0; ra1 = '0; ra2 = '0;
        m_pc = '0; m_wen = 1'b0; m_dst = '0; m_data = '0;
        repeat (2) cycle();
        @(negedge clk);
        checks++; if (commit_valid !== 1'b0) $display("[TB] FAIL reset_commit: got %b want 0", commit_valid); else passed++;
        checks++; if (tranw.valid !== 1'b0) $display("[TB] FAIL reset_tranw: got %b want 0", tranw.valid); else passed++;
        checks++; if (instret !== 64'd0) $display("[TB] FAIL reset_instret: got %0d want 0", instret); else passed++;
        cycle();
        reset = 1'b0;
        exp_instret = '0;
    endtask

    task automatic test_write();
        drive_entry(64'h1000, 1'b1, 5'd5, 64'hDEAD_BEEF, 1);
        cycle();
        m_valid = 1'b0; ra1 = 5'd5;
        @(negedge clk);
        checks++;
        if (commit_valid === 1'b1 && sb.size() > 0) begin
            passed++; c = sb.pop_front();
            checks++; if (commit_pc !== c.pc) $display("[TB] FAIL write_pc: got %h want %h", commit_pc, c.pc); else passed++;
            checks++; if (commit_wdata !== c.wdata) $display("[TB] FAIL write_wdata: got %h want %h", commit_wdata, c.wdata); else passed++;
        end else $display("[TB] FAIL write_commit: got %b want 1 (queued %0d)", commit_valid, sb.size());
        checks++; if (tranw.valid !== 1'b1 || tranw.dst !== 5'd5) $display("[TB] FAIL write_tranw: got v=%b d=%0d want v=1 d=5", tranw.valid, tranw.dst); else passed++;
        cycle();
        @(negedge clk);
        checks++; if (commit_valid !== 1'b0) $display("[TB] FAIL write_single_pulse: got %b want 0", commit_valid); else passed++;
        checks++; if (instret !== exp_instret) $display("[TB] FAIL write_instret: got %0d want %0d", instret, exp_instret); else passed++;
        checks++; if (rd1 !== 64'hDEAD_BEEF) $display("[TB] FAIL write_rd1: got %h want deadbeef", rd1); else passed++;
        cycle();
    endtask

    task automatic test_x0();
        drive_entry(64'h1004, 1'b1, 5'd0, 64'h1234, 1);
        cycle();
        m_valid = 1'b0; ra1 = 5'd0;
        @(negedge clk);
        checks++; if (tranw.valid !== 1'b0) $display("[TB] FAIL x0_tranw: got %b want 0", tranw.valid); else passed++;
        checks++;
        if (commit_valid === 1'b1 && sb.size() > 0) begin
            passed++; c = sb.pop_front();
            checks++; if (commit_wdata !== c.wdata) $display("[TB] FAIL x0_wdata: got %h want %h", commit_wdata, c.wdata); else passed++;
        end else $display("[TB] FAIL x0_commit: got %b want 1 (queued %0d)", commit_valid, sb.size());
        cycle();
        @(negedge clk);
        checks++; if (rd1 !== 64'd0) $display("[TB] FAIL x0_rd1: got %h want 0", rd1); else passed++;
        checks++; if (instret !== exp_instret) $display("[TB] FAIL x0_instret: got %0d want %0d", instret, exp_instret); else passed++;
        cycle();
    endtask

    task automatic test_no_wen();
        drive_entry(64'h1008, 1'b0, 5'd4, 64'hFFFF, 1);
        cycle();
        m_valid = 1'b0;
        @(negedge clk);
        checks++; if (tranw.valid !== 1'b0) $display("[TB] FAIL nowen_tranw: got %b want 0", tranw.valid); else passed++;
        checks++;
        if (commit_valid === 1'b1 && sb.size() > 0) begin
            passed++; c = sb.pop_front();
            checks++; if (commit_wdata !== c.wdata) $display("[TB] FAIL nowen_wdata: got %h want %h", commit_wdata, c.wdata); else passed++;
        end else $display("[TB] FAIL nowen_commit: got %b want 1 (queued %0d)", commit_valid, sb.size());
        cycle();
    endtask

    task automatic test_hold();
        int pulses = 0;
        drive_entry(64'h1010, 1'b1, 5'd7, 64'h55, 1);
        cycle();
        m_valid = 1'b0; hold = 1'b1; ra1 = 5'd7;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (tranw.valid !== 1'b1 || tranw.data !== 64'h55) $display("[TB] FAIL hold_tranw_%0d: got v=%b d=%h want v=1 d=55", i, tranw.valid, tranw.data); else passed++;
            if (commit_valid === 1'b1) begin
                pulses++;
                if (pulses == 1 && sb.size() > 0) begin
                    c = sb.pop_front();
                    checks++; if (commit_pc !== c.pc) $display("[TB] FAIL hold_pc: got %h want %h", commit_pc, c.pc); else passed++;
                end
            end
            cycle();
            if (i == 2) hold = 1'b0;
        end
        checks++; if (pulses != 1) $display("[TB] FAIL hold_pulses: got %0d want 1", pulses); else passed++;
        @(negedge clk);
        checks++; if (instret !== exp_instret) $display("[TB] FAIL hold_instret: got %0d want %0d", instret, exp_instret); else passed++;
        checks++; if (rd1 !== 64'h55) $display("[TB] FAIL hold_rd1: got %h want 55", rd1); else passed++;
        checks++; if (tranw.valid !== 1'b0) $display("[TB] FAIL hold_drain: got %b want 0", tranw.valid); else passed++;
        cycle();
    endtask

    task automatic test_bypass();
        logic [63:0] want_rd2;
`ifdef WB_READ_BYPASS_EN
        want_rd2 = 64'h77;
`else
        want_rd2 = 64'h11;
`endif
        drive_entry(64'h1020, 1'b1, 5'd9, 64'h11, 1);
        cycle();
        drive_entry(64'h1024, 1'b1, 5'd9, 64'h77, 1);
        @(negedge clk);
        checks++;
        if (commit_valid === 1'b1 && sb.size() > 0) begin
            passed++; c = sb.pop_front();
            checks++; if (commit_pc !== c.pc) $display("[TB] FAIL bypass_pc_a: got %h want %h", commit_pc, c.pc); else passed++;
        end else $display("[TB] FAIL bypass_commit_a: got %b want 1 (queued %0d)", commit_valid, sb.size());
        cycle();
        m_valid = 1'b0; hold = 1'b1; ra2 = 5'd9;
        @(negedge clk);
        checks++; if (rd2 !== want_rd2) $display("[TB] FAIL bypass_rd2: got %h want %h", rd2, want_rd2); else passed++;
        checks++;
        if (commit_valid === 1'b1 && sb.size() > 0) begin
            passed++; c = sb.pop_front();
            checks++; if (commit_pc !== c.pc) $display("[TB] FAIL bypass_pc_b: got %h want %h", commit_pc, c.pc); else passed++;
        end else $display("[TB] FAIL bypass_commit_b: got %b want 1 (queued %0d)", commit_valid, sb.size());
        cycle();
        @(negedge clk);
        checks++; if (rd2 !== 64'h77) $display("[TB] FAIL bypass_written: got %h want 77", rd2); else passed++;
        checks++; if (commit_valid !== 1'b0) $display("[TB] FAIL bypass_held_commit: got %b want 0", commit_valid); else passed++;
        hold = 1'b0;
        cycle();
    endtask

    task automatic test_back_to_back();
        drive_entry(64'h1030, 1'b1, 5'd3, 64'd1, 1);
        cycle();
        drive_entry(64'h1034, 1'b1, 5'd3, 64'd2, 1);
        @(negedge clk);
        checks++;
        if (commit_valid === 1'b1 && sb.size() > 0) begin
            passed++; c = sb.pop_front();
            checks++; if (commit_wdata !== c.wdata) $display("[TB] FAIL b2b_wdata_a: got %h want %h", commit_wdata, c.wdata); else passed++;
        end else $display("[TB] FAIL b2b_commit_a: got %b want 1 (queued %0d)", commit_valid, sb.size());
        cycle();
        m_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (commit_valid === 1'b1 && sb.size() > 0) begin
            passed++; c = sb.pop_front();
            checks++; if (commit_pc !== c.pc) $display("[TB] FAIL b2b_pc_b: got %h want %h", commit_pc, c.pc); else passed++;
        end else $display("[TB] FAIL b2b_commit_b: got %b want 1 (queued %0d)", commit_valid, sb.size());
        cycle();
        ra1 = 5'd3;
        @(negedge clk);
        checks++; if (rd1 !== 64'd2) $display("[TB] FAIL b2b_x3: got %h want 2", rd1); else passed++;
        checks++; if (instret !== exp_instret) $display("[TB] FAIL b2b_instret: got %0d want %0d", instret, exp_instret); else passed++;
        cycle();
    endtask

    task automatic test_reset_mid_hold();
        drive_entry(64'h1040, 1'b1, 5'd12, 64'h99, 1);
        cycle();
        m_valid = 1'b0;
        @(negedge clk);
        checks++; if (commit_valid === 1'b1 && sb.size() > 0) begin passed++; c = sb.pop_front(); end
        else $display("[TB] FAIL rst_pre_commit: got %b want 1 (queued %0d)", commit_valid, sb.size());
        cycle();
        drive_entry(64'h1044, 1'b1, 5'd12, 64'hAB, 0);
        cycle();
        m_valid = 1'b0; hold = 1'b1; ra1 = 5'd12;
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (commit_valid !== 1'b0) $display("[TB] FAIL rst_hold_commit: got %b want 0", commit_valid); else passed++;
        checks++; if (tranw.valid !== 1'b0) $display("[TB] FAIL rst_hold_tranw: got %b want 0", tranw.valid); else passed++;
        cycle();
        reset = 1'b0; hold = 1'b0; exp_instret = '0;
        @(negedge clk);
        checks++; if (commit_valid !== 1'b0) $display("[TB] FAIL rst_after_commit: got %b want 0", commit_valid); else passed++;
        checks++; if (instret !== exp_instret) $display("[TB] FAIL rst_instret: got %0d want 0", instret); else passed++;
        checks++; if (tranw.valid !== 1'b0) $display("[TB] FAIL rst_after_tranw: got %b want 0", tranw.valid); else passed++;
        checks++; if (rd1 !== 64'h99) $display("[TB] FAIL rst_no_write: got %h want 99", rd1); else passed++;
        cycle();
    endtask

    initial begin
        test_reset();
        test_write();
        test_x0();
        test_no_wen();
        test_hold();
        test_bypass();
        test_back_to_back();
        test_reset_mid_hold();
        checks++; if (sb.size() != 0) $display("[TB] FAIL scoreboard_drain: got %0d pending want 0", sb.size()); else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
